wl_decoder: RTL
===============

WL_DECODER -- requirements
Module: wl_decoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning row-address width.
REQ-002 The block SHALL have parameter NUM_ROWS, default 32, meaning the number of word lines; legal range is 2 to 2**ADDR_W.
REQ-003 The block SHALL have a single clock and synchronous, active-low reset; all other ports are listed below.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  synchronous active-low reset.
REQ-006 req_valid_i  input  1  request present.
REQ-007 req_ready_o  output  1  request accepted when valid and ready are both high in the same cycle.
REQ-008 req_mode_i  input  1  0 = single decode, 1 = sweep.
REQ-009 req_addr_i  input  ADDR_W  row address (single) or start row (sweep).
REQ-010 abort_i  input  1  terminates a sweep.
REQ-011 wl_o  output  NUM_ROWS  registered one-hot word-line select.
REQ-012 wl_valid_o  output  1  wl_o carries a driven row this cycle.
REQ-013 busy_o  output  1  a sweep is in progress.
REQ-014 done_o  output  1  one-cycle pulse with the final sweep row.
REQ-015 err_o  output  1  one-cycle pulse on a rejected request.

Function
REQ-016 The FSM SHALL have states IDLE and SWEEP; wl_o, wl_valid_o, done_o and err_o SHALL be registered outputs.
REQ-017 req_ready_o SHALL be 1 in IDLE and 0 in SWEEP.
REQ-018 Single decode accepted in cycle N SHALL drive wl_o[req_addr_i]=1 (all other bits 0) with wl_valid_o=1 in cycle N+1 only; the FSM stays in IDLE.
REQ-019 Back-to-back single requests SHALL produce one driven row per cycle with no bubble.
REQ-020 With no accepted request and not in SWEEP, wl_o SHALL be all-zero and wl_valid_o SHALL be 0.
REQ-021 An accepted request with req_addr_i >= NUM_ROWS SHALL set err_o=1 in cycle N+1 with wl_o all-zero and wl_valid_o=0; no sweep starts.
REQ-022 A sweep accepted in cycle N with start S SHALL drive rows S, S+1, ..., NUM_ROWS-1 in cycles N+1 through N+NUM_ROWS-S, one row per cycle, with wl_valid_o=1 throughout.
REQ-023 done_o SHALL be 1 in the cycle that drives row NUM_ROWS-1; the FSM SHALL be in IDLE with req_ready_o=1 in the following cycle.
REQ-024 A sweep with S=NUM_ROWS-1 SHALL drive one row with done_o=1 in the same cycle.
REQ-025 busy_o SHALL be 1 from cycle N+1 through the done_o cycle inclusive.
REQ-026 abort_i=1 in SWEEP SHALL make wl_o all-zero, wl_valid_o=0 and busy_o=0 in the next cycle, with no done_o; abort takes priority over the final row.
REQ-027 abort_i SHALL have no effect in IDLE, including when it coincides with an accepted request.
REQ-028 wl_o SHALL never have more than one bit set.

Reset
REQ-029 While rst_ni=0 at a clock edge, the FSM SHALL enter IDLE, wl_o SHALL be 0, wl_valid_o, busy_o, done_o and err_o SHALL be 0, and the row counter SHALL be 0.
REQ-030 During reset req_ready_o SHALL be 1, but no request is accepted in a cycle where rst_ni=0.
REQ-031 Reset asserted mid-sweep SHALL clear the sweep with no done_o; the first request after reset release SHALL behave as from power-up.

Configuration
REQ-032 Macro WL_DEC_SWEEP_EN defined: sweep mode, abort_i, busy_o and done_o operate as specified above.
REQ-033 Macro WL_DEC_SWEEP_EN undefined: there SHALL be no SWEEP state; an accepted req_mode_i=1 request SHALL give err_o=1 in the next cycle with no row driven; abort_i is ignored; busy_o and done_o are tied to 0; ports are unchanged.

Verification
REQ-034 Default parameters, single decode, addr 0 then addr 31 back-to-back -> wl_o=0x00000001 then 0x80000000 on consecutive cycles, then 0.
REQ-035 NUM_ROWS=24, single decode, addr 26 -> err_o pulses once, wl_o=0, wl_valid_o=0.
REQ-036 Default parameters, sweep from start 28 -> rows 28, 29, 30 and 31 driven over 4 cycles; done_o with 0x80000000; req_ready_o=1 on the 5th cycle.
REQ-037 Sweep from start 0 with abort_i in the 3rd busy cycle -> rows 0, 1 and 2 driven, then wl_o=0, busy_o=0, no done_o.
REQ-038 Sweep from start 10 with rst_ni=0 in the 2nd busy cycle -> all outputs 0 next cycle; a new single decode at addr 5 then gives wl_o=0x00000020.
REQ-039 WL_DEC_SWEEP_EN undefined, sweep request with addr 3 -> err_o pulse, wl_o=0, busy_o=0.

Source files
------------

// File: rtl/wl_decoder.sv
// Word-line decoder: registered one-hot row select with single-row and sweep modes.
// Sweep mode, abort_i, busy_o and done_o are enabled by defining WL_DEC_SWEEP_EN.
module wl_decoder #(
  parameter int ADDR_W   = 5,
  parameter int NUM_ROWS = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_mode_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                abort_i,
  output logic [NUM_ROWS-1:0] wl_o,
  output logic                wl_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam logic [ADDR_W:0] LP_NUM_ROWS = NUM_ROWS[ADDR_W:0];

  logic [NUM_ROWS-1:0] r_wl;
  logic                r_wl_valid;
  logic                r_done;
  logic                r_err;
  logic                w_wl_valid_next;
  logic                w_done_next;
  logic                w_err_next;
  logic [ADDR_W-1:0]   w_sel_row;
  logic [NUM_ROWS-1:0] w_onehot;
  logic                w_accept;
  logic                w_addr_bad;

`ifdef WL_DEC_SWEEP_EN
  localparam int              LP_LAST_INT = NUM_ROWS - 1;
  localparam logic [ADDR_W-1:0] LP_LAST_ROW = LP_LAST_INT[ADDR_W-1:0];

  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] w_row_next;

  // Ready is forced high while in reset; acceptance is still blocked by rst_ni.
  assign req_ready_o = (r_state == ST_IDLE) | ~rst_ni;
  assign busy_o      = (r_state == ST_SWEEP);
`else
  logic w_unused_abort;

  assign w_unused_abort = abort_i;
  assign req_ready_o    = 1'b1;
  assign busy_o         = 1'b0;
`endif

  assign w_accept   = req_valid_i & req_ready_o & rst_ni;
  assign w_addr_bad = ({1'b0, req_addr_i} >= LP_NUM_ROWS);

  always_comb begin
    w_sel_row       = req_addr_i;
    w_wl_valid_next = 1'b0;
    w_done_next     = 1'b0;
    w_err_next      = 1'b0;
`ifdef WL_DEC_SWEEP_EN
    w_state_next    = r_state;
    w_row_next      = r_row;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_addr_bad) begin
            w_err_next = 1'b1;
          end else begin
            w_wl_valid_next = 1'b1;
            if (req_mode_i) begin
              w_state_next = ST_SWEEP;
              w_row_next   = req_addr_i;
              w_done_next  = (req_addr_i == LP_LAST_ROW);
            end
          end
        end
      end
      ST_SWEEP: begin
        // Abort is checked first so it also cancels the last row.
        if (abort_i || (r_row == LP_LAST_ROW)) begin
          w_state_next = ST_IDLE;
        end else begin
          w_row_next      = r_row + 1'b1;
          w_sel_row       = w_row_next;
          w_wl_valid_next = 1'b1;
          w_done_next     = (w_row_next == LP_LAST_ROW);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
`else
    if (w_accept) begin
      if (w_addr_bad || req_mode_i) begin
        w_err_next = 1'b1;
      end else begin
        w_wl_valid_next = 1'b1;
      end
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_onehot
      localparam int LP_IDX = gi;
      assign w_onehot[gi] = w_wl_valid_next && (w_sel_row == LP_IDX[ADDR_W-1:0]);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wl       <= '0;
      r_wl_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wl       <= w_onehot;
      r_wl_valid <= w_wl_valid_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
    end
  end

`ifdef WL_DEC_SWEEP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;
    end
  end
`endif

  assign wl_o       = r_wl;
  assign wl_valid_o = r_wl_valid;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule
